// File: rtl/modbus_pkg.sv
// Shared types and limits for the Modbus RTU TX data stream.
package modbus_pkg;

   typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_t;

   localparam int unsigned MB_MAX_WR_REGS = 123;
   localparam int unsigned MB_MAX_RD_REGS = 125;
   localparam int unsigned MB_REG_W       = 16;

   // Index wide enough to count 0..num inclusive.
   function automatic int unsigned idx_width(input int unsigned num);
      return $clog2(num + 1);
   endfunction

endpackage

// File: rtl/modbus_tx_data_stream_if.sv
// Valid/ready word stream from the TX snapshot to the frame builder.
interface modbus_tx_data_stream_if #(
   parameter int unsigned DATA_W = 16
) ();
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/modbus_tx_data_stream_shadow_bank.sv
// NUM x DATA_W capture register with a load strobe, an indexed read port and a flat view.
module modbus_shadow_bank #(
   parameter int unsigned NUM    = 30,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IDX_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [NUM*DATA_W-1:0] d,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_W-1:0]     rd_data,
   output logic [NUM*DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

   // Out-of-range indices read as zero.
   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         if (rd_idx == IDX_W'(k)) begin
            rd_data = q[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/modbus_tx_data_stream.sv
// Captures all write registers on frame_start and streams them word-by-word to the frame builder.
// Optional TX_MUX_CHANGE_DET_EN keeps the previous snapshot and flags whether the new one differs.
module modbus_tx_data_stream
   import modbus_pkg::*;
#(
   parameter int unsigned SLAVE_ADR           = 1,
   parameter int unsigned ADR_FIRST_REG_WRITE = 300,
   parameter int unsigned NUM_REG_WRITE       = 30,
   parameter int unsigned ADR_FIRST_REG_READ  = 340,
   parameter int unsigned NUM_REG_READ        = 30,
   parameter int unsigned DATA_W              = MB_REG_W
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REG_WRITE*DATA_W-1:0] data_in,
   input  logic                            frame_start,
   input  logic                            abort,
   modbus_tx_data_stream_if.master         tx,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            data_changed,
   output logic [7:0]                      adr,
   output logic [15:0]                     adr_first_reg_tx,
   output logic [7:0]                      num_reg_tx,
   output logic [15:0]                     adr_first_reg_rx,
   output logic [7:0]                      num_reg_rx
);

   localparam int unsigned IDX_W = idx_width(NUM_REG_WRITE);
   localparam int unsigned FLAT_W = NUM_REG_WRITE * DATA_W;

   if (NUM_REG_WRITE < 1 || NUM_REG_WRITE > MB_MAX_WR_REGS) begin : g_bad_num_reg_write
      $fatal(1, "NUM_REG_WRITE must be in 1..%0d", MB_MAX_WR_REGS);
   end

   assign adr              = 8'(SLAVE_ADR);
   assign adr_first_reg_tx = 16'(ADR_FIRST_REG_WRITE);
   assign num_reg_tx       = 8'(NUM_REG_WRITE);
   assign adr_first_reg_rx = 16'(ADR_FIRST_REG_READ);
   assign num_reg_rx       = 8'(NUM_REG_READ);

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [DATA_W-1:0]   rd_data, data_q, data_n;
   logic                valid_q, last_q;
   logic                load;
   logic [FLAT_W-1:0]   shadow_q_unused;

   assign load = (state == CAPTURE) && !abort;

   modbus_shadow_bank #(
      .NUM    (NUM_REG_WRITE),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .d       (data_in),
      .rd_idx  (idx_n),
      .rd_data (rd_data),
      .q       (shadow_q_unused)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         data_q     <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         valid_q    <= (state_n == STREAM);
         last_q     <= (state_n == STREAM) && (idx_n == IDX_W'(NUM_REG_WRITE - 1));
         data_q     <= data_n;
         busy       <= (state_n != IDLE);
         frame_done <= (state_n == DONE);
      end
   end

   // Next state and word index; abort overrides everything.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      unique case (state)
         IDLE: begin
            if (frame_start) state_n = CAPTURE;
         end
         CAPTURE: begin
            state_n = STREAM;
            idx_n   = '0;
         end
         STREAM: begin
            if (tx.out_ready) begin
               if (idx == IDX_W'(NUM_REG_WRITE - 1)) begin
                  state_n = DONE;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (abort) begin
         state_n = IDLE;
         idx_n   = '0;
      end
   end

   // The shadow is only written on the CAPTURE edge, so word 0 bypasses it.
   always_comb begin
      data_n = data_q;
      if (state_n == STREAM) begin
         data_n = (state == CAPTURE) ? data_in[DATA_W-1:0] : rd_data;
      end
   end

   assign tx.out_valid = valid_q;
   assign tx.out_last  = last_q;
   assign tx.out_data  = data_q;

`ifdef TX_MUX_CHANGE_DET_EN
   logic [FLAT_W-1:0] prev_q;
   logic [DATA_W-1:0] prev_rd_unused;
   logic              first_frame;

   modbus_shadow_bank #(
      .NUM    (NUM_REG_WRITE),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_prev (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .d       (data_in),
      .rd_idx  ('0),
      .rd_data (prev_rd_unused),
      .q       (prev_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_changed <= 1'b1;
         first_frame  <= 1'b1;
      end else if (load) begin
         data_changed <= (data_in != prev_q) || first_frame;
         first_frame  <= 1'b0;
      end
   end
`else
   assign data_changed = 1'b1;
`endif

endmodule

// File: tb/tb_modbus_tx_data_stream.sv
// Randomised and directed bench for modbus_tx_data_stream against a frame-level reference model.
module tb_modbus_tx_data_stream;

   localparam int unsigned N = 30;
   localparam int unsigned W = 16;
`ifdef TX_MUX_CHANGE_DET_EN
   localparam bit CHG_DET = 1'b1;
`else
   localparam bit CHG_DET = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*W-1:0] data_in = '0;
   logic           frame_start = 1'b0;
   logic           abort = 1'b0;
   logic           busy, frame_done, data_changed;
   logic [7:0]     adr, num_reg_tx, num_reg_rx;
   logic [15:0]    adr_first_reg_tx, adr_first_reg_rx;

   modbus_tx_data_stream_if #(.DATA_W(W)) tx ();

   modbus_tx_data_stream dut (
      .clk              (clk),
      .reset_n          (rst_n),
      .data_in          (data_in),
      .frame_start      (frame_start),
      .abort            (abort),
      .tx               (tx),
      .busy             (busy),
      .frame_done       (frame_done),
      .data_changed     (data_changed),
      .adr              (adr),
      .adr_first_reg_tx (adr_first_reg_tx),
      .num_reg_tx       (num_reg_tx),
      .adr_first_reg_rx (adr_first_reg_rx),
      .num_reg_rx       (num_reg_rx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a frame is "requested", then "captured", then words are handed out one per accept.
   logic [N*W-1:0] m_snap, m_prev;
   bit             m_cap, m_stream, m_done, m_chg, m_first;
   int             m_ptr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cap <= 0; m_stream <= 0; m_done <= 0; m_ptr <= 0;
         m_snap <= '0; m_prev <= '0; m_chg <= 1; m_first <= 1;
      end else if (abort) begin
         m_cap <= 0; m_stream <= 0; m_done <= 0; m_ptr <= 0;
      end else if (m_cap) begin
         m_snap   <= data_in;
         m_chg    <= CHG_DET ? ((data_in != m_prev) || m_first) : 1'b1;
         m_prev   <= data_in;
         m_first  <= 0;
         m_cap    <= 0;
         m_stream <= 1;
         m_ptr    <= 0;
      end else if (m_stream) begin
         if (tx.out_ready) begin
            if (m_ptr == N - 1) begin
               m_stream <= 0; m_done <= 1; m_ptr <= 0;
            end else begin
               m_ptr <= m_ptr + 1;
            end
         end
      end else if (m_done) begin
         m_done <= 0;
      end else if (frame_start) begin
         m_cap <= 1;
      end
   end

   // Per-frame monitor records.
   logic [W-1:0] acc_q[$];
   int           valid_cycles, first_valid, done_cyc, last_cnt;
   logic [W-1:0] last_word;

   task automatic clr_mon();
      acc_q.delete();
      valid_cycles = 0; first_valid = -1; done_cyc = -1; last_cnt = 0; last_word = '0;
   endtask

   always @(negedge clk) begin
      chk("out_valid", tx.out_valid, m_stream);
      if (m_stream) begin
         chk("out_data", tx.out_data, m_snap[m_ptr*W +: W]);
         chk("out_last", tx.out_last, (m_ptr == N - 1));
      end
      chk("busy", busy, m_cap || m_stream || m_done);
      chk("frame_done", frame_done, m_done);
      chk("data_changed", data_changed, m_chg);
      if (tx.out_valid === 1'b1) begin
         valid_cycles++;
         if (first_valid < 0) first_valid = cyc;
         if (tx.out_ready) begin
            acc_q.push_back(tx.out_data);
            if (tx.out_last) begin
               last_cnt++;
               last_word = tx.out_data;
            end
         end
      end
      if (frame_done === 1'b1) done_cyc = cyc;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_seq();
      for (int k = 0; k < N; k++) data_in[k*W +: W] = W'(16'h0100 + k);
   endtask

   int fs_cyc;
   task automatic run_frame();
      clr_mon();
      tx.out_ready = 1'b1;
      frame_start  = 1'b1;
      fs_cyc       = cyc;
      step(1);
      frame_start  = 1'b0;
      step(34);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, tx.out_valid, 0);
      chk({tag, "_out_data"}, tx.out_data, 0);
      chk({tag, "_out_last"}, tx.out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_data_changed"}, data_changed, 1);
   endtask

   initial begin
      bit ok;
      tx.out_ready = 1'b0;
      clr_mon();
      step(2);
      chk_reset_outputs("rst");
      chk("adr", adr, 8'd1);
      chk("adr_first_reg_tx", adr_first_reg_tx, 16'd300);
      chk("num_reg_tx", num_reg_tx, 8'd30);
      chk("adr_first_reg_rx", adr_first_reg_rx, 16'd340);
      chk("num_reg_rx", num_reg_rx, 8'd30);
      rst_n = 1'b1;
      step(1);

      // Full-rate frame.
      set_seq();
      run_frame();
      chk("t1_first_valid_cyc", first_valid, fs_cyc + 2);
      chk("t1_words", acc_q.size(), N);
      chk("t1_word0", acc_q[0], 16'h0100);
      chk("t1_word29", acc_q[N-1], 16'h011D);
      chk("t1_last_cnt", last_cnt, 1);
      chk("t1_last_word", last_word, 16'h011D);
      chk("t1_done_cyc", done_cyc, fs_cyc + 32);

      // Ready alternating 1,0,1,0: 30 accepts with 29 stalls in between.
      clr_mon();
      frame_start = 1'b1;
      fs_cyc = cyc;
      tx.out_ready = 1'b1;
      for (int i = 0; i < 70; i++) begin
         step(1);
         frame_start = 1'b0;
         tx.out_ready = ~tx.out_ready;
      end
      ok = (acc_q.size() == N);
      for (int k = 0; k < acc_q.size(); k++) if (acc_q[k] != W'(16'h0100 + k)) ok = 0;
      chk("t2_order", ok, 1);
      chk("t2_valid_cycles", valid_cycles, 59);
      chk("t2_done_cyc", done_cyc, fs_cyc + 61);

      // Data changes after capture and frame_start while busy are both ignored.
      clr_mon();
      tx.out_ready = 1'b1;
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(1);
      data_in = {N{16'hFFFF}};
      step(2);
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(32);
      chk("t3_words", acc_q.size(), N);
      chk("t3_word0", acc_q[0], 16'h0100);
      chk("t3_word29", acc_q[N-1], 16'h011D);
      chk("t3_idle", busy, 0);
      run_frame();
      chk("t3b_words", acc_q.size(), N);
      chk("t3b_word0", acc_q[0], 16'hFFFF);
      chk("t3b_word29", acc_q[N-1], 16'hFFFF);
      chk("t3b_changed", data_changed, 1);

      // Abort after word 5 has been accepted.
      set_seq();
      clr_mon();
      tx.out_ready = 1'b1;
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(7);
      abort = 1'b1;
      tx.out_ready = 1'b0;
      step(1);
      abort = 1'b0;
      chk("t4_valid_after_abort", tx.out_valid, 0);
      chk("t4_words", acc_q.size(), 6);
      chk("t4_word5", acc_q[5], 16'h0105);
      step(5);
      chk("t4_no_done", done_cyc, -1);
      chk("t4_idle", busy, 0);
      run_frame();
      chk("t4_restart_word0", acc_q[0], 16'h0100);
      chk("t4_restart_words", acc_q.size(), N);

      // Asynchronous reset mid-stream.
      clr_mon();
      tx.out_ready = 1'b1;
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(9);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t5");
      step(2);
      rst_n = 1'b1;
      step(1);

      // Change detection: identical data twice, then word 29 modified.
      set_seq();
      run_frame();
      chk("t6_first", data_changed, 1);
      run_frame();
      chk("t6_same", data_changed, CHG_DET ? 0 : 1);
      data_in[(N-1)*W +: W] = 16'h1234;
      run_frame();
      chk("t6_modified", data_changed, 1);

      // Random traffic; data drawn from a small pool so repeat snapshots occur.
      for (int i = 0; i < 1500; i++) begin
         tx.out_ready = ($urandom_range(0, 3) != 0);
         frame_start  = ($urandom_range(0, 5) == 0);
         abort        = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 9) == 0) begin
            int k;
            k = $urandom_range(0, N - 1);
            data_in[k*W +: W] = ($urandom_range(0, 1) == 0) ? W'(16'h0100 + k) : W'($urandom);
         end
         if ($urandom_range(0, 199) == 0) set_seq();
         step(1);
      end
      abort = 1'b0;
      frame_start = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
